rr_arbiter16: RTL and testbench

- Round-robin arbiter that shares one resource among 16 requesters.
- Issues a registered 4-bit grant index and a one-hot 16-bit grant. The one-hot grant is produced by the team's existing 4-to-16 `decoder`.
- Sits between requesting agents and the shared datapath port.
- Optional hold limit stops one requester from starving the others.

---
 rtl/rr_arbiter16_pkg.sv | 37 +++
 rtl/rr_arbiter16_decoder.sv | 11 +
 rtl/rr_arbiter16.sv | 72 +++++++
 tb/tb_rr_arbiter16.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/rr_arbiter16_pkg.sv
// Shared definitions for the 16-way round-robin arbiter: sizes, FSM encoding
// and the rotating priority search used to pick the next owner.
package rr_arbiter16_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } win_t;

  // Rotate req so that bit 'start' lands at position 0, then take the lowest
  // set bit; the returned index is translated back with 4-bit wrap.
  function automatic win_t pick_winner(input logic [N_REQ-1:0] req,
                                       input logic [IDX_W-1:0] start);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    win_t               w;
    dbl = {req, req} >> start;
    rot = dbl[N_REQ-1:0];
    w   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        w.found = 1'b1;
        w.idx   = start + IDX_W'(i);
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter16_decoder.sv
// 4-to-16 binary-to-one-hot decoder used to expand the grant index.
module decoder
  import rr_arbiter16_pkg::*;
(
  input  logic [IDX_W-1:0] in,
  output logic [N_REQ-1:0] out
);

  assign out = N_REQ'(1) << in;

endmodule

// File: rtl/rr_arbiter16.sv
// Round-robin arbiter for 16 requesters with an optional hold limit that
// forces a handoff once the owner has held MAX_HOLD cycles under contention.
module rr_arbiter16
  import rr_arbiter16_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [N_REQ-1:0] gnt
);

  localparam int              HC_W     = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HC_W-1:0] HOLD_MAX = HC_W'(MAX_HOLD);
  localparam bit              HOLD_EN  = (MAX_HOLD != 0);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [HC_W-1:0]  hold_cnt;

  logic [N_REQ-1:0] owner_mask;
  logic [N_REQ-1:0] others;
  logic [N_REQ-1:0] gnt_raw;
  win_t             win;
  logic             owner_req;
  logic             hold_expired;
  logic             take_new;
  logic             go_idle;

  // The current owner is masked out so it can never re-win its own handoff.
  always_comb begin
    owner_mask   = (state == ST_GRANT) ? (N_REQ'(1) << gnt_idx) : '0;
    others       = req & ~owner_mask;
    win          = pick_winner(others, ptr);
    owner_req    = req[gnt_idx];
    hold_expired = HOLD_EN && (hold_cnt == HOLD_MAX);
    take_new     = win.found && ((state == ST_IDLE) || !owner_req || hold_expired);
    go_idle      = (state == ST_GRANT) && !owner_req && !win.found;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
      ptr       <= '0;
      hold_cnt  <= '0;
    end else if (take_new) begin
      state     <= ST_GRANT;
      gnt_valid <= 1'b1;
      gnt_idx   <= win.idx;
      ptr       <= win.idx + IDX_W'(1);
      hold_cnt  <= HC_W'(1);
    end else if (go_idle) begin
      state     <= ST_IDLE;
      gnt_valid <= 1'b0;
    end else if (state == ST_GRANT && HOLD_EN && hold_cnt != HOLD_MAX) begin
      hold_cnt  <= hold_cnt + HC_W'(1);
    end
  end

  decoder u_decoder (
    .in  (gnt_idx),
    .out (gnt_raw)
  );

  assign gnt = gnt_raw & {N_REQ{gnt_valid}};

endmodule

// File: tb/tb_rr_arbiter16.sv
// Scoreboard bench for rr_arbiter16: three instances (MAX_HOLD 8, 4, 0) driven
// with directed vectors; expected grants are queued and checked after each edge.
module tb_rr_arbiter16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [3];
  logic [15:0] req [3];
  logic        gv  [3];
  logic [3:0]  gi  [3];
  logic [15:0] g   [3];

  rr_arbiter16 #(.MAX_HOLD(8)) u_h8 (
    .clk(clk), .rst(rst[0]), .req(req[0]), .gnt_valid(gv[0]), .gnt_idx(gi[0]), .gnt(g[0]));
  rr_arbiter16 #(.MAX_HOLD(4)) u_h4 (
    .clk(clk), .rst(rst[1]), .req(req[1]), .gnt_valid(gv[1]), .gnt_idx(gi[1]), .gnt(g[1]));
  rr_arbiter16 #(.MAX_HOLD(0)) u_h0 (
    .clk(clk), .rst(rst[2]), .req(req[2]), .gnt_valid(gv[2]), .gnt_idx(gi[2]), .gnt(g[2]));

  typedef struct {
    int         at;
    int         dut;
    logic       valid;
    logic [3:0] idx;
    logic       strict;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   edge_cnt = 0;
  int   checks   = 0;
  int   errors   = 0;

  task automatic push_exp(input int d, input logic v, input logic [3:0] i,
                          input string n, input logic s);
    exp_t x;
    x.at     = edge_cnt + 1;
    x.dut    = d;
    x.valid  = v;
    x.idx    = i;
    x.strict = s;
    x.name   = n;
    sb.push_back(x);
  endtask

  // Drive one DUT at the falling edge and queue what it must show after the next rising edge.
  task automatic cyc(input int d, input logic r, input logic [15:0] q,
                     input logic v, input logic [3:0] i, input string n);
    @(negedge clk);
    rst[d] = r;
    req[d] = q;
    push_exp(d, v, i, n, r);
  endtask

  initial begin
    logic [15:0] want_gnt;
    forever begin
      @(posedge clk);
      #1;
      edge_cnt++;
      while (sb.size() > 0 && sb[0].at <= edge_cnt) begin
        e        = sb.pop_front();
        want_gnt = e.valid ? (16'h0001 << e.idx) : 16'h0000;
        checks++;
        if (e.at != edge_cnt || gv[e.dut] !== e.valid || g[e.dut] !== want_gnt ||
            ((e.valid || e.strict) && gi[e.dut] !== e.idx)) begin
          errors++;
          $display("FAIL %s dut%0d edge %0d: got valid=%0b idx=%0d gnt=%h, want valid=%0b idx=%0d gnt=%h",
                   e.name, e.dut, edge_cnt, gv[e.dut], gi[e.dut], g[e.dut],
                   e.valid, e.idx, want_gnt);
        end
      end
    end
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1;
      req[d] = 16'hFFFF;
    end

    // reset dominates a full request vector
    repeat (3) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        rst[d] = 1'b1;
        req[d] = 16'hFFFF;
        push_exp(d, 1'b0, 4'd0, "reset_hold", 1'b1);
      end
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b0;
      req[d] = 16'hFFFF;
      push_exp(d, 1'b1, 4'd0, "first_after_reset", 1'b0);
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      req[d] = 16'h0000;
      push_exp(d, 1'b0, 4'd0, "release_idle", 1'b0);
    end

    // single requester, never preempted
    cyc(0, 1'b0, 16'h0020, 1'b1, 4'd5, "single_grant");
    repeat (20) cyc(0, 1'b0, 16'h0020, 1'b1, 4'd5, "single_hold");
    cyc(0, 1'b0, 16'h0000, 1'b0, 4'd0, "single_release");

    // ptr=6: owner 3, then release hands to 7, then wraps to 1
    cyc(0, 1'b0, 16'h0008, 1'b1, 4'd3, "handoff_owner3");
    cyc(0, 1'b0, 16'h008A, 1'b1, 4'd3, "handoff_hold3");
    cyc(0, 1'b0, 16'h0082, 1'b1, 4'd7, "handoff_to7");
    cyc(0, 1'b0, 16'h0002, 1'b1, 4'd1, "handoff_to1");
    cyc(0, 1'b0, 16'h0000, 1'b0, 4'd0, "handoff_idle");

    // reset mid-grant, then search restarts at 0
    cyc(0, 1'b0, 16'h0200, 1'b1, 4'd9, "rst_owner9");
    cyc(0, 1'b0, 16'h0210, 1'b1, 4'd9, "rst_hold9");
    cyc(0, 1'b0, 16'h0210, 1'b1, 4'd9, "rst_hold9");
    cyc(0, 1'b1, 16'h0210, 1'b0, 4'd0, "rst_mid_grant");
    cyc(0, 1'b0, 16'h0210, 1'b1, 4'd4, "rst_regrant");
    cyc(0, 1'b0, 16'h0000, 1'b0, 4'd0, "rst_idle");

    // MAX_HOLD=4 alternation across the 15->0 wrap
    cyc(1, 1'b1, 16'h0000, 1'b0, 4'd0, "h4_reset");
    for (int k = 0; k < 24; k++)
      cyc(1, 1'b0, 16'h8001, 1'b1, (((k / 4) % 2) == 0) ? 4'd0 : 4'd15, "wrap_rr");
    cyc(1, 1'b0, 16'h0000, 1'b0, 4'd0, "wrap_idle");

    // MAX_HOLD=0 never preempts
    cyc(2, 1'b1, 16'h0000, 1'b0, 4'd0, "h0_reset");
    cyc(2, 1'b0, 16'h0004, 1'b1, 4'd2, "unl_owner2");
    repeat (50) cyc(2, 1'b0, 16'hFFFF, 1'b1, 4'd2, "unl_hold");
    cyc(2, 1'b0, 16'hFFFB, 1'b1, 4'd3, "unl_handoff");
    cyc(2, 1'b0, 16'h0000, 1'b0, 4'd0, "unl_idle");

    for (int t = 0; t < 10 && sb.size() > 0; t++) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
